// File: rtl/seq_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_accumulator_pkg
// Description : Shared FSM encoding and default sizing for seq_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_accumulator_pkg;

    // Job controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default operand/sum width and operand-count field width
    localparam int c_DEFAULT_N     = 4;
    localparam int c_DEFAULT_CNT_W = 4;

endpackage : seq_accumulator_pkg
`default_nettype wire

// File: rtl/seq_accumulator_rca.sv
`default_nettype none
// ============================================================================
// Module      : N_RCA
// Description : N-bit ripple-carry adder built from a chain of full adders.
// Revision    : 1.0 - initial release
// ============================================================================
module N_RCA #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    // One full adder per bit; carry ripples from LSB to MSB
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[N];

endmodule : N_RCA
`default_nettype wire

// File: rtl/seq_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : seq_accumulator
// Description : Streaming multi-operand accumulator. Accepts a programmed
//               number of operands over valid/ready, sums them through the
//               ripple-carry adder and presents sum plus sticky carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_accumulator
    import seq_accumulator_pkg::*;
#(
    parameter int N     = c_DEFAULT_N,
    parameter int CNT_W = c_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_t           r_state;
    logic [N-1:0]     r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_remaining;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [N-1:0]     w_sum;
    logic             w_cout;

    // Running sum plus the next operand; carry-in is never used
    N_RCA #(
        .N (N)
    ) u_rca (
        .a    (r_acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Job controller: state, datapath registers and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_remaining <= len;
                            r_in_ready  <= 1'b1;
                            r_state     <= ACCUM;
                        end else begin
                            // Empty job goes straight to a zero result
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end

                ACCUM: begin
                    if (in_valid && r_in_ready) begin
                        r_acc       <= w_sum;
                        r_ovf       <= r_ovf | w_cout;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    // start arriving with the handshake is deliberately dropped
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;

endmodule : seq_accumulator
`default_nettype wire
